// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scanner states, key map and command codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  localparam logic [3:0] KEY_IDLE = 4'd15;
  localparam logic [3:0] KEY_ADD  = 4'd10;
  localparam logic [3:0] KEY_SUB  = 4'd11;
  localparam logic [3:0] KEY_MUL  = 4'd12;

  // KEYMAP[row][col]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'd1,  4'd2, 4'd3,  4'd10},
    '{4'd4,  4'd5, 4'd6,  4'd11},
    '{4'd7,  4'd8, 4'd9,  4'd12},
    '{4'd14, 4'd0, 4'd15, 4'd13}
  };

  // Index of the lowest-numbered active-low row; lower rows win on multi-key presses.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high.
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  // Next-state: shift the raw rows through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer registers, released high so no key appears pressed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce; one key_valid per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEB_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [3:0]       row_s;
  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       row_pat_q, row_pat_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  // Scan/debounce FSM next-state and output logic.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_cnt_d   = div_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    row_pat_d   = row_pat_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    case (state_q)
      SCAN: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (row_s == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            row_pat_d = row_s;
            row_idx_d = lowest_low(row_s);
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_s != row_pat_q) begin
          deb_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SCAN;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d = '0;
          state_d   = PRESSED;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      PRESSED: begin
        key_code_d  = KEYMAP[row_idx_q][col_q];
        key_valid_d = 1'b1;
        key_down_d  = 1'b1;
        deb_cnt_d   = '0;
        state_d     = RELEASE;
      end

      RELEASE: begin
        // Only the latched row matters; other keys are ignored until release.
        if (!row_s[row_idx_q]) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d  = '0;
          div_cnt_d  = '0;
          key_down_d = 1'b0;
          col_d      = col_q + 2'd1;
          state_d    = SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_q       <= '0;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      row_pat_q   <= '1;
      row_idx_q   <= '0;
      key_code_q  <= KEY_IDLE;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      div_cnt_q   <= div_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      row_pat_q   <= row_pat_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  // One-hot-low column drive decoded from the column index.
  always_comb begin
    col_n        = '1;
    col_n[col_q] = 1'b0;
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model, reference model and per-cycle compare.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // keys[r*4+c] = 1 means the key at row r, column c is held
  logic [15:0] keys = '0;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [3:0] last_code = 4'd15;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Physical matrix: a held key shorts its row to its column when that column is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // ---------------- reference model ----------------
  string KEYS = "123A456B789C*0#D";

  function automatic logic [3:0] code_of(input int r, input int c);
    logic [7:0] ch;
    ch = KEYS[r*4+c];
    case (ch)
      "A": return 4'd10;
      "B": return 4'd11;
      "C": return 4'd12;
      "D": return 4'd13;
      "*": return 4'd14;
      "#": return 4'd15;
      default: return 4'(ch - 8'h30);
    endcase
  endfunction

  // phase: 0 scanning, 1 confirming press, 2 reporting, 3 waiting for release
  int         m_phase, m_col, m_tick, m_stable, m_quiet, m_row;
  logic [3:0] m_s1, m_s2, m_pat, m_code, m_raw, m_rs;
  logic       m_valid, m_down;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_col = 0; m_tick = 0; m_stable = 0; m_quiet = 0; m_row = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF;
      m_code = 4'd15; m_valid = 1'b0; m_down = 1'b0;
    end else begin
      m_raw = 4'hF;
      for (int r = 0; r < 4; r++) if (keys[r*4+m_col]) m_raw[r] = 1'b0;
      m_rs = m_s2;
      m_s2 = m_s1;
      m_s1 = m_raw;
      m_valid = 1'b0;
      if (m_phase == 0) begin
        if (m_tick == SD - 1) begin
          m_tick = 0;
          if (m_rs == 4'hF) m_col = (m_col + 1) % 4;
          else begin
            m_pat = m_rs;
            m_row = 0;
            while (m_rs[m_row]) m_row++;
            m_stable = 0;
            m_phase = 1;
          end
        end else m_tick++;
      end else if (m_phase == 1) begin
        if (m_rs != m_pat) begin m_stable = 0; m_phase = 0; end
        else if (m_stable == DB - 1) begin m_stable = 0; m_phase = 2; end
        else m_stable++;
      end else if (m_phase == 2) begin
        m_code = code_of(m_row, m_col);
        m_valid = 1'b1;
        m_down = 1'b1;
        m_quiet = 0;
        m_phase = 3;
      end else begin
        if (!m_rs[m_row]) m_quiet = 0;
        else if (m_quiet == DB - 1) begin
          m_quiet = 0; m_down = 1'b0; m_col = (m_col + 1) % 4; m_tick = 0; m_phase = 0;
        end else m_quiet++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, plus pulse bookkeeping.
  logic [3:0] exp_col;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_col = 4'hF;
      exp_col[m_col] = 1'b0;
      check("col_n", 32'(col_n), 32'(exp_col));
      check("key_code", 32'(key_code), 32'(m_code));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_down", 32'(key_down), 32'(m_down));
      if (key_valid) begin
        pulses++;
        last_code = key_code;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"}, 32'(col_n), 32'(4'b1110));
    check({tag, "_key_code"}, 32'(key_code), 32'd15);
    check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_key_down"}, 32'(key_down), 32'd0);
  endtask

  logic [3:0] walk [4];
  int p0;
  int waited;

  initial begin
    walk[0] = 4'b1101; walk[1] = 4'b1011; walk[2] = 4'b0111; walk[3] = 4'b1110;

    // 1: reset and idle column walk
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle(SD);
      check("walk_col", 32'(col_n), 32'(walk[k]));
    end
    idle(20);
    check("idle_no_pulse", 32'(pulses), 32'd0);

    // 2: long hold of key 6, single pulse, release timing
    p0 = pulses;
    keys[1*4+2] = 1'b1;
    idle(200);
    check("hold_pulses", 32'(pulses - p0), 32'd1);
    check("hold_code", 32'(last_code), 32'd6);
    check("hold_down", 32'(key_down), 32'd1);
    keys = '0;
    idle(8);
    check("release_down_still", 32'(key_down), 32'd1);
    idle(4);
    check("release_down_low", 32'(key_down), 32'd0);
    idle(30);

    // 3: bouncing key A, then stable
    p0 = pulses;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) keys[0*4+3] = ~keys[0*4+3];
      @(negedge clk);
    end
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    keys[0*4+3] = 1'b1;
    idle(60);
    check("bounce_pulses", 32'(pulses - p0), 32'd1);
    check("bounce_code", 32'(last_code), 32'd10);
    keys = '0;
    idle(30);

    // 4: two keys in column 0, lower row wins
    p0 = pulses;
    keys[2*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    idle(60);
    check("multi_pulses", 32'(pulses - p0), 32'd1);
    check("multi_code", 32'(last_code), 32'd7);
    keys = '0;
    idle(30);

    // 5: key 0 then key 9
    p0 = pulses;
    keys[3*4+1] = 1'b1;
    idle(60);
    check("seq_first_code", 32'(last_code), 32'd0);
    keys = '0;
    idle(20);
    check("seq_gap_down", 32'(key_down), 32'd0);
    keys[2*4+2] = 1'b1;
    idle(60);
    check("seq_pulses", 32'(pulses - p0), 32'd2);
    check("seq_second_code", 32'(last_code), 32'd9);
    keys = '0;
    idle(30);

    // 6: reset in the middle of press confirmation
    p0 = pulses;
    keys[0] = 1'b1;
    waited = 0;
    while (!(m_phase == 1 && m_stable == 5) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("mid_debounce_reached", 32'(waited < 200), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    keys = '0;
    idle(2);
    rst_n = 1'b1;
    idle(60);
    check("interrupted_no_pulse", 32'(pulses - p0), 32'd0);
    keys[0] = 1'b1;
    idle(60);
    check("redebounce_pulses", 32'(pulses - p0), 32'd1);
    check("redebounce_code", 32'(last_code), 32'd1);
    keys = '0;
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
